ahb_store_master: RTL and testbench

- Store-side counterpart of the load sign/zero-extension path: accepts one store request from the core's memory stage and performs a single AHB-Lite write transfer.
- Steers store data onto byte lanes, drives the address and data phases, and honours wait states and the two-cycle ERROR response.
- Returns a one-cycle done or error pulse to the core.
- Non-pipelined: at most one outstanding transfer.

---
 rtl/ahb_store_master_if.sv | 52 +++++
 rtl/ahb_store_master.sv | 237 +++++++++++++++++++++++
 tb/tb_ahb_store_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_store_master_if.sv
// -----------------------------------------------------------------------------
// ahb_store_master_if
//
// Bundles the core-side store request handshake and the AHB-Lite master
// signals used by ahb_store_master.
//
// Signal summary:
//   Core side : st_valid, st_addr[31:0], st_size[1:0], st_data[31:0]  (to block)
//               st_ready, st_done, st_err                             (from block)
//   AHB side  : haddr[31:0], htrans[1:0], hwrite, hsize[2:0],
//               hburst[2:0], hprot[3:0], hwdata[31:0]                 (from block)
//               hready, hresp                                         (to block)
//
// Modports:
//   master : the store master's view (drives st_ready/st_done/st_err and AHB)
//   slave  : the environment's view (core requester plus AHB slave)
// -----------------------------------------------------------------------------
interface ahb_store_master_if;

    // Core store request / completion
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;

    // AHB-Lite master signals
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  st_valid, st_addr, st_size, st_data, hready, hresp,
        output st_ready, st_done, st_err,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

    modport slave (
        output st_valid, st_addr, st_size, st_data, hready, hresp,
        input  st_ready, st_done, st_err,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
    );

endinterface

// File: rtl/ahb_store_master.sv
// -----------------------------------------------------------------------------
// ahb_store_master
//
// Accepts one store request from the core's memory stage and performs a single
// AHB-Lite write transfer (SINGLE burst, NONSEQ). Store data is replicated onto
// all byte lanes according to the access size, wait states are honoured in both
// the address and data phases, and the two-cycle ERROR response is absorbed.
// Completion is reported with a one-cycle st_done (OKAY) or st_err (bus ERROR,
// misaligned address or illegal size) pulse. Only one transfer is ever in
// flight.
//
// Parameters:
//   ERR_ON_MISALIGN : 1 -> misaligned requests are rejected with st_err and
//                          never reach the bus
//                     0 -> the address is force-aligned and the write issued
//   HPROT_VAL       : constant driven on hprot
//
// Ports:
//   hclk : system clock
//   hrst : asynchronous, active-high reset
//   bus  : ahb_store_master_if.master (core handshake + AHB master signals)
//
// Timing (zero wait states): request accepted at edge 0, address phase in
// cycle 1, data phase in cycle 2, st_done/st_err pulse in cycle 3, st_ready
// high again in cycle 4. A rejected request pulses st_err in cycle 1.
// -----------------------------------------------------------------------------
module ahb_store_master #(
    parameter bit         ERR_ON_MISALIGN = 1'b1,
    parameter logic [3:0] HPROT_VAL       = 4'b0011
) (
    input logic                  hclk,
    input logic                  hrst,
    ahb_store_master_if.master   bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_ILL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Replicate right-justified store data across every byte lane it could
    // occupy, so the slave picks the right lane from haddr/hsize alone.
    function automatic logic [31:0] steer_lanes(input logic [31:0] d,
                                                input logic [1:0]  sz);
        logic [31:0] r;
        case (sz)
            SIZE_BYTE: r = {4{d[7:0]}};
            SIZE_HALF: r = {2{d[15:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

    // Clear the low address bits that the access size does not allow.
    function automatic logic [31:0] align_addr(input logic [31:0] a,
                                               input logic [1:0]  sz);
        logic [31:0] r;
        case (sz)
            SIZE_BYTE: r = a;
            SIZE_HALF: r = {a[31:1], 1'b0};
            default:   r = {a[31:2], 2'b00};
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a,
                                           input logic [1:0]  sz);
        return ((sz == SIZE_HALF) && a[0]) ||
               ((sz == SIZE_WORD) && (a[1:0] != 2'b00));
    endfunction

    // A request that must be answered with st_err without touching the bus.
    function automatic logic is_illegal(input logic [31:0] a,
                                        input logic [1:0]  sz);
        return (sz == SIZE_ILL) || (ERR_ON_MISALIGN && is_misaligned(a, sz));
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t      state,     state_n;
    logic [31:0] haddr_q,   haddr_n;
    logic [1:0]  htrans_q,  htrans_n;
    logic        hwrite_q,  hwrite_n;
    logic [2:0]  hsize_q,   hsize_n;
    logic [31:0] hwdata_q,  hwdata_n;
    logic        done_q,    done_n;
    logic        err_q,     err_n;

    // Lane-steered write data captured at request acceptance; only consumed
    // when the data phase starts, so it needs no reset.
    logic [31:0] wdata_q,   wdata_n;

    logic        accept;

    assign accept = bus.st_valid && (state == S_IDLE);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        haddr_n  = haddr_q;
        htrans_n = htrans_q;
        hwrite_n = hwrite_q;
        hsize_n  = hsize_q;
        hwdata_n = hwdata_q;
        wdata_n  = wdata_q;
        done_n   = 1'b0;
        err_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    wdata_n = steer_lanes(bus.st_data, bus.st_size);
                    if (is_illegal(bus.st_addr, bus.st_size)) begin
                        // Rejected: the bus outputs stay idle, only the
                        // error pulse is produced.
                        err_n   = 1'b1;
                        state_n = S_RESP;
                    end else begin
                        haddr_n  = align_addr(bus.st_addr, bus.st_size);
                        hsize_n  = {1'b0, bus.st_size};
                        htrans_n = HTRANS_NONSEQ;
                        hwrite_n = 1'b1;
                        state_n  = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                // Address-phase signals are simply held while hready is low.
                if (bus.hready) begin
                    htrans_n = HTRANS_IDLE;
                    hwrite_n = 1'b0;
                    hwdata_n = wdata_q;
                    state_n  = S_DATA;
                end
            end

            S_DATA: begin
                // hready low covers ordinary waits and the first cycle of an
                // ERROR response; the response is only taken with hready high.
                if (bus.hready) begin
                    done_n  = !bus.hresp;
                    err_n   = bus.hresp;
                    state_n = S_RESP;
                end
            end

            S_RESP: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state    <= S_IDLE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            haddr_q  <= haddr_n;
            htrans_q <= htrans_n;
            hwrite_q <= hwrite_n;
            hsize_q  <= hsize_n;
            hwdata_q <= hwdata_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_ff @(posedge hclk) begin
        wdata_q <= wdata_n;
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    // st_ready is combinational on hrst so it drops the moment reset asserts.
    assign bus.st_ready = (state == S_IDLE) && !hrst;
    assign bus.st_done  = done_q;
    assign bus.st_err   = err_q;

    assign bus.haddr    = haddr_q;
    assign bus.htrans   = htrans_q;
    assign bus.hwrite   = hwrite_q;
    assign bus.hsize    = hsize_q;
    assign bus.hwdata   = hwdata_q;
    assign bus.hburst   = HBURST_SINGLE;
    assign bus.hprot    = HPROT_VAL;

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_pulse_exclusive: assert property (@(posedge hclk) disable iff (hrst)
        !(done_q && err_q));

    a_pulse_in_resp: assert property (@(posedge hclk) disable iff (hrst)
        (done_q || err_q) |-> (state == S_RESP));

    a_addr_hold: assert property (@(posedge hclk) disable iff (hrst)
        (state == S_ADDR && !bus.hready) |=>
            ($stable(haddr_q) && $stable(hsize_q) && htrans_q == HTRANS_NONSEQ));

    a_wdata_hold: assert property (@(posedge hclk) disable iff (hrst)
        (state == S_DATA && !bus.hready) |=> $stable(hwdata_q));

endmodule

// File: tb/tb_ahb_store_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_store_master
//
// Directed bench for ahb_store_master. Two instances share clock and reset:
// dut rejects misaligned requests, dut_na force-aligns them. All expected
// values are hand-computed constants written next to each stimulus.
// -----------------------------------------------------------------------------
module tb_ahb_store_master;

    logic hclk;
    logic hrst;

    ahb_store_master_if bus();
    ahb_store_master_if bus_na();

    ahb_store_master #(
        .ERR_ON_MISALIGN (1'b1),
        .HPROT_VAL       (4'b0011)
    ) dut (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus.master)
    );

    ahb_store_master #(
        .ERR_ON_MISALIGN (1'b0),
        .HPROT_VAL       (4'b0011)
    ) dut_na (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus_na.master)
    );

    int checks = 0;
    int errors = 0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits for the next negedge, confirms st_ready, presents a request and
    // lets it be taken at the following posedge (edge 0). Returns 1 time unit
    // into cycle 1 with st_valid already dropped.
    task automatic start(input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data);
        @(negedge hclk);
        chk("ready_before_req", {31'd0, bus.st_ready}, 32'd1);
        bus.st_addr  = addr;
        bus.st_size  = size;
        bus.st_data  = data;
        bus.st_valid = 1'b1;
        @(posedge hclk);
        #1;
        bus.st_valid = 1'b0;
    endtask

    // Next-cycle helper: waits for the negedge of the next cycle.
    task automatic next_cyc();
        @(negedge hclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        hrst            = 1'b1;
        bus.st_valid    = 1'b0;
        bus.st_addr     = '0;
        bus.st_size     = '0;
        bus.st_data     = '0;
        bus.hready      = 1'b1;
        bus.hresp       = 1'b0;
        bus_na.st_valid = 1'b0;
        bus_na.st_addr  = '0;
        bus_na.st_size  = '0;
        bus_na.st_data  = '0;
        bus_na.hready   = 1'b1;
        bus_na.hresp    = 1'b0;

        // ---------------- reset values ----------------
        @(negedge hclk);
        chk("rst_ready",  {31'd0, bus.st_ready}, 32'd0);
        chk("rst_haddr",  bus.haddr, 32'd0);
        chk("rst_htrans", {30'd0, bus.htrans}, 32'd0);
        chk("rst_hwrite", {31'd0, bus.hwrite}, 32'd0);
        chk("rst_hsize",  {29'd0, bus.hsize}, 32'd0);
        chk("rst_hwdata", bus.hwdata, 32'd0);
        chk("rst_done",   {31'd0, bus.st_done}, 32'd0);
        chk("rst_err",    {31'd0, bus.st_err}, 32'd0);
        chk("hburst",     {29'd0, bus.hburst}, 32'd0);
        chk("hprot",      {28'd0, bus.hprot}, 32'h3);
        @(negedge hclk);
        hrst = 1'b0;

        // ---------------- word store, zero wait ----------------
        start(32'h1000_0008, 2'd2, 32'hDEAD_BEEF);
        next_cyc(); // cycle 1
        chk("w_c1_htrans", {30'd0, bus.htrans}, 32'h2);
        chk("w_c1_haddr",  bus.haddr, 32'h1000_0008);
        chk("w_c1_hsize",  {29'd0, bus.hsize}, 32'h2);
        chk("w_c1_hwrite", {31'd0, bus.hwrite}, 32'd1);
        chk("w_c1_ready",  {31'd0, bus.st_ready}, 32'd0);
        next_cyc(); // cycle 2
        chk("w_c2_hwdata", bus.hwdata, 32'hDEAD_BEEF);
        chk("w_c2_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("w_c2_hwrite", {31'd0, bus.hwrite}, 32'd0);
        chk("w_c2_done",   {31'd0, bus.st_done}, 32'd0);
        next_cyc(); // cycle 3
        chk("w_c3_done",   {31'd0, bus.st_done}, 32'd1);
        chk("w_c3_err",    {31'd0, bus.st_err}, 32'd0);
        chk("w_c3_ready",  {31'd0, bus.st_ready}, 32'd0);

        // ---------------- byte store ----------------
        start(32'h0000_0023, 2'd0, 32'h0000_00A5);
        next_cyc();
        chk("b_c1_haddr",  bus.haddr, 32'h23);
        chk("b_c1_hsize",  {29'd0, bus.hsize}, 32'h0);
        next_cyc();
        chk("b_c2_hwdata", bus.hwdata, 32'hA5A5_A5A5);
        next_cyc();
        chk("b_c3_done",   {31'd0, bus.st_done}, 32'd1);

        // ---------------- half store (upper data bits ignored) ----------------
        start(32'h0000_0042, 2'd1, 32'hFFFF_1234);
        next_cyc();
        chk("h_c1_haddr",  bus.haddr, 32'h42);
        chk("h_c1_hsize",  {29'd0, bus.hsize}, 32'h1);
        next_cyc();
        chk("h_c2_hwdata", bus.hwdata, 32'h1234_1234);
        next_cyc();
        chk("h_c3_done",   {31'd0, bus.st_done}, 32'd1);

        // ---------------- word store, 3 data-phase wait states ----------------
        start(32'h0000_0200, 2'd2, 32'hCAFE_F00D);
        next_cyc(); // cycle 1
        chk("ws_c1_htrans", {30'd0, bus.htrans}, 32'h2);
        for (int c = 2; c <= 5; c++) begin
            @(posedge hclk);
            #1;
            bus.hready = (c == 5);
            @(negedge hclk);
            chk($sformatf("ws_c%0d_hwdata", c), bus.hwdata, 32'hCAFE_F00D);
            chk($sformatf("ws_c%0d_htrans", c), {30'd0, bus.htrans}, 32'h0);
            chk($sformatf("ws_c%0d_done", c), {31'd0, bus.st_done}, 32'd0);
        end
        next_cyc(); // cycle 6
        chk("ws_c6_done", {31'd0, bus.st_done}, 32'd1);

        // ---------------- address wait then slave ERROR ----------------
        start(32'h0000_0300, 2'd2, 32'h1111_2222);
        bus.hready = 1'b0;          // stall the address phase one cycle
        next_cyc(); // cycle 1
        chk("e_c1_htrans", {30'd0, bus.htrans}, 32'h2);
        @(posedge hclk);
        #1;
        bus.hready = 1'b1;
        @(negedge hclk); // cycle 2, still address phase
        chk("e_c2_htrans", {30'd0, bus.htrans}, 32'h2);
        chk("e_c2_haddr",  bus.haddr, 32'h300);
        @(posedge hclk);
        #1;
        bus.hresp  = 1'b1;          // first ERROR cycle
        bus.hready = 1'b0;
        @(negedge hclk); // cycle 3, data phase
        chk("e_c3_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("e_c3_err",    {31'd0, bus.st_err}, 32'd0);
        @(posedge hclk);
        #1;
        bus.hready = 1'b1;          // second ERROR cycle
        @(negedge hclk); // cycle 4
        chk("e_c4_err",    {31'd0, bus.st_err}, 32'd0);
        @(posedge hclk);
        #1;
        bus.hresp = 1'b0;
        @(negedge hclk); // cycle 5
        chk("e_c5_err",    {31'd0, bus.st_err}, 32'd1);
        chk("e_c5_done",   {31'd0, bus.st_done}, 32'd0);
        next_cyc(); // cycle 6
        chk("e_c6_err",    {31'd0, bus.st_err}, 32'd0);
        chk("e_c6_ready",  {31'd0, bus.st_ready}, 32'd1);

        // ---------------- misaligned half rejected ----------------
        start(32'h0000_0101, 2'd1, 32'h0000_BEEF);
        next_cyc();
        chk("mh_c1_err",    {31'd0, bus.st_err}, 32'd1);
        chk("mh_c1_done",   {31'd0, bus.st_done}, 32'd0);
        chk("mh_c1_htrans", {30'd0, bus.htrans}, 32'h0);
        next_cyc();
        chk("mh_c2_err",    {31'd0, bus.st_err}, 32'd0);
        chk("mh_c2_ready",  {31'd0, bus.st_ready}, 32'd1);
        chk("mh_c2_htrans", {30'd0, bus.htrans}, 32'h0);

        // ---------------- misaligned word rejected ----------------
        start(32'h0000_0202, 2'd2, 32'h0);
        next_cyc();
        chk("mw_c1_err",    {31'd0, bus.st_err}, 32'd1);
        chk("mw_c1_htrans", {30'd0, bus.htrans}, 32'h0);

        // ---------------- illegal size ----------------
        start(32'h0000_0040, 2'd3, 32'h0);
        next_cyc();
        chk("is_c1_err",    {31'd0, bus.st_err}, 32'd1);
        chk("is_c1_htrans", {30'd0, bus.htrans}, 32'h0);
        next_cyc();
        chk("is_c2_ready",  {31'd0, bus.st_ready}, 32'd1);
        chk("is_c2_htrans", {30'd0, bus.htrans}, 32'h0);

        // ---------------- force-align instance ----------------
        @(negedge hclk);
        chk("na_ready", {31'd0, bus_na.st_ready}, 32'd1);
        bus_na.st_addr  = 32'h0000_0101;
        bus_na.st_size  = 2'd1;
        bus_na.st_data  = 32'h0000_BEEF;
        bus_na.st_valid = 1'b1;
        @(posedge hclk);
        #1;
        bus_na.st_valid = 1'b0;
        next_cyc();
        chk("na_c1_haddr",  bus_na.haddr, 32'h100);
        chk("na_c1_htrans", {30'd0, bus_na.htrans}, 32'h2);
        chk("na_c1_hsize",  {29'd0, bus_na.hsize}, 32'h1);
        next_cyc();
        chk("na_c2_hwdata", bus_na.hwdata, 32'hBEEF_BEEF);
        next_cyc();
        chk("na_c3_done",   {31'd0, bus_na.st_done}, 32'd1);
        chk("na_c3_err",    {31'd0, bus_na.st_err}, 32'd0);

        // ---------------- reset during data wait state ----------------
        start(32'h0000_0400, 2'd2, 32'h55AA_55AA);
        @(posedge hclk);
        #1;
        bus.hready = 1'b0;
        @(negedge hclk); // cycle 2, data phase waiting
        chk("r_c2_hwdata", bus.hwdata, 32'h55AA_55AA);
        #2;
        hrst = 1'b1;
        #1;
        chk("r_htrans", {30'd0, bus.htrans}, 32'h0);
        chk("r_hwdata", bus.hwdata, 32'h0);
        chk("r_ready",  {31'd0, bus.st_ready}, 32'd0);
        chk("r_done",   {31'd0, bus.st_done}, 32'd0);
        chk("r_err",    {31'd0, bus.st_err}, 32'd0);
        bus.hready = 1'b1;
        @(negedge hclk);
        chk("r_hold_done", {31'd0, bus.st_done}, 32'd0);
        chk("r_hold_err",  {31'd0, bus.st_err}, 32'd0);
        hrst = 1'b0;

        // ---------------- normal store after reset ----------------
        start(32'h0000_0500, 2'd2, 32'h0BAD_F00D);
        next_cyc();
        chk("p_c1_haddr",  bus.haddr, 32'h500);
        chk("p_c1_htrans", {30'd0, bus.htrans}, 32'h2);
        next_cyc();
        chk("p_c2_hwdata", bus.hwdata, 32'h0BAD_F00D);
        next_cyc();
        chk("p_c3_done",   {31'd0, bus.st_done}, 32'd1);
        next_cyc();
        chk("p_c4_done",   {31'd0, bus.st_done}, 32'd0);
        chk("p_c4_ready",  {31'd0, bus.st_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
